// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 DIV/DIVU unit for the MIPS execute stage
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   start          request a divide (sampled in IDLE only)
//   signed_div     1 = DIV (two's complement), 0 = DIVU; sampled with start
//   annul          abort the in-flight divide; blocks acceptance in IDLE
//   a, b           dividend, divisor
//   busy           pipeline stall request
//   done           one-cycle pulse, result valid
//   result         {remainder, quotient} = {HI, LO}
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, DIVZ, RUN, FIN} state_t;

  state_t           state;
  logic             sdiv_q;
  logic             sa_q;
  logic             sb_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;   // holds the dividend, quotient bits shift in at the LSB
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // |0x80..0| stays 0x80..0 when read as unsigned, which is what we want.
  assign a_mag = (signed_div && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign b_mag = (signed_div && b[WIDTH-1]) ? (~b + 1'b1) : b;

  // One restoring step; the extra top bit catches the borrow.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign diff      = rem_shift - {1'b0, dvs_q};
  assign ge        = ~diff[WIDTH];
  assign rem_next  = ge ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign quo_next  = {quo_q[WIDTH-2:0], ge};

  // Quotient takes the XOR of the signs, remainder follows the dividend.
  assign neg_q   = sdiv_q & (sa_q ^ sb_q);
  assign neg_r   = sdiv_q & sa_q;
  assign quo_fix = neg_q ? (~quo_next + 1'b1) : quo_next;
  assign rem_fix = neg_r ? (~rem_next + 1'b1) : rem_next;

  assign busy = ((state == IDLE) && start && !annul) || (state == DIVZ) || (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      done   <= 1'b0;
      result <= '0;
      cnt_q  <= '0;
      sdiv_q <= 1'b0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !annul) begin
            sdiv_q <= signed_div;
            sa_q   <= a[WIDTH-1];
            sb_q   <= b[WIDTH-1];
            dvs_q  <= b_mag;
            rem_q  <= '0;
            cnt_q  <= '0;
            if (b == '0) begin
              quo_q <= a;          // raw dividend becomes the remainder
              state <= DIVZ;
            end else begin
              quo_q <= a_mag;
              state <= RUN;
            end
          end
        end
        DIVZ: begin
          if (annul) begin
            state <= IDLE;
          end else begin
            result <= {quo_q, {WIDTH{1'b1}}};
            done   <= 1'b1;
            state  <= FIN;
          end
        end
        RUN: begin
          if (annul) begin
            state <= IDLE;
          end else begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            cnt_q <= cnt_q + 1'b1;
            // Last iteration: commit the corrected result so it is valid during FIN.
            if (cnt_q == CW'(WIDTH - 1)) begin
              result <= {rem_fix, quo_fix};
              done   <= 1'b1;
              state  <= FIN;
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
